// File: rtl/spi_reg_slave_if.sv
// SPI pin bundle for spi_reg_slave. The master drives select, clock and
// data-out; the slave returns data-in and the pad output enable.
interface spi_reg_slave_if;
  logic ss;
  logic sclk;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (
    output ss,
    output sclk,
    output mosi,
    input  miso,
    input  miso_oe
  );

  modport slave (
    input  ss,
    input  sclk,
    input  mosi,
    output miso,
    output miso_oe
  );
endinterface

// File: rtl/spi_reg_slave.sv
// SPI slave with a small register bank. The SPI pins are oversampled in the
// sys_clk domain. All four CPOL/CPHA modes, read and write, and address
// auto-increment within one select window are supported.
//
// Write notification: wr_strobe is a single-cycle pulse with no backpressure.
// wr_addr is valid only in that cycle. regs already holds the new value in the
// same cycle.
module spi_reg_slave #(
  parameter int               DATA_W    = 8,
  parameter int               ADDR_W    = 3,
  parameter bit               SS_ACTIVE = 1'b1,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                              sys_clk,
  input  logic                              rst_n,
  spi_reg_slave_if.slave                    spi,
  input  logic                              cpol,
  input  logic                              cpha,
  output logic [(2**ADDR_W)*DATA_W-1:0]     regs,
  output logic                              wr_strobe,
  output logic [ADDR_W-1:0]                 wr_addr,
  output logic                              frame_err,
  output logic [1:0]                        dbg_state
);

  localparam int NREGS = 2**ADDR_W;
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_DATA = 2'd2
  } state_e;

  // Synchronisers and edge pipeline
  logic [1:0] ss_sync_q, sclk_sync_q, mosi_sync_q;
  logic       sclk_prev_q;
  logic       samp_q, shft_q, mosi_bit_q;
  logic       cpol_q, cpha_q;
  logic       ss_act, sclk_edge, lead_edge, trail_edge;

  // FSM and datapath state
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rx_q, rx_d, rx_next;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_inc;
  logic              is_wr_q, is_wr_d;
  logic              skip_q, skip_d;
  logic              miso_q, miso_d;
  logic              wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              frame_err_q, frame_err_d;
  logic              reg_we;
  logic [DATA_W-1:0] regs_q [NREGS];

  assign ss_act     = (ss_sync_q[1] == SS_ACTIVE);
  assign sclk_edge  = sclk_sync_q[1] ^ sclk_prev_q;
  assign lead_edge  = sclk_edge & (sclk_sync_q[1] != cpol_q);
  assign trail_edge = sclk_edge & (sclk_sync_q[1] == cpol_q);

  // Two-flop synchronisers plus a registered sample/shift edge pulse
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_sync_q   <= {2{~SS_ACTIVE}};
      sclk_sync_q <= 2'b00;
      mosi_sync_q <= 2'b00;
      sclk_prev_q <= 1'b0;
      samp_q      <= 1'b0;
      shft_q      <= 1'b0;
      mosi_bit_q  <= 1'b0;
    end else begin
      ss_sync_q   <= {ss_sync_q[0], spi.ss};
      sclk_sync_q <= {sclk_sync_q[0], spi.sclk};
      mosi_sync_q <= {mosi_sync_q[0], spi.mosi};
      sclk_prev_q <= sclk_sync_q[1];
      samp_q      <= cpha_q ? trail_edge : lead_edge;
      shft_q      <= cpha_q ? lead_edge : trail_edge;
      mosi_bit_q  <= mosi_sync_q[1];
    end
  end

  // Mode pins are only taken while deselected, so a mode change mid-frame waits
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
    end else if (state_q == S_IDLE && !ss_act) begin
      cpol_q <= cpol;
      cpha_q <= cpha;
    end
  end

  // FSM and datapath state registers
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      addr_q      <= '0;
      is_wr_q     <= 1'b0;
      skip_q      <= 1'b0;
      miso_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      addr_q      <= addr_d;
      is_wr_q     <= is_wr_d;
      skip_q      <= skip_d;
      miso_q      <= miso_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Register bank: written with the completed word at the current address
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= RESET_VAL;
    end else if (reg_we) begin
      regs_q[addr_q] <= rx_next;
    end
  end

  // Next-state logic. A freshly loaded tx word arms skip_q so that the first
  // shift edge after the load leaves the MSB on miso. That edge is the trailing
  // edge of the last bit when cpha=0, or the first leading edge of the word
  // when cpha=1.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    addr_d      = addr_q;
    is_wr_d     = is_wr_q;
    skip_d      = skip_q;
    reg_we      = 1'b0;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    frame_err_d = 1'b0;
    rx_next     = {rx_q[DATA_W-2:0], mosi_bit_q};
    addr_inc    = addr_q + 1'b1;

    unique case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        tx_d   = '0;
        skip_d = 1'b0;
        if (ss_act) state_d = S_CMD;
      end

      S_CMD: begin
        if (!ss_act) begin
          state_d     = S_IDLE;
          frame_err_d = (cnt_q != '0);
        end else if (samp_q) begin
          rx_d = rx_next;
          if (cnt_q == LAST_BIT) begin
            cnt_d   = '0;
            is_wr_d = rx_next[DATA_W-1];
            addr_d  = rx_next[ADDR_W-1:0];
            tx_d    = rx_next[DATA_W-1] ? '0 : regs_q[rx_next[ADDR_W-1:0]];
            skip_d  = 1'b1;
            state_d = S_DATA;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_DATA: begin
        if (!ss_act) begin
          state_d     = S_IDLE;
          frame_err_d = (cnt_q != '0);
        end else if (samp_q) begin
          rx_d = rx_next;
          if (cnt_q == LAST_BIT) begin
            cnt_d  = '0;
            addr_d = addr_inc;
            skip_d = 1'b1;
            if (is_wr_q) begin
              reg_we      = 1'b1;
              wr_strobe_d = 1'b1;
              wr_addr_d   = addr_q;
              tx_d        = '0;
            end else begin
              tx_d = regs_q[addr_inc];
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (shft_q) begin
          if (skip_q) skip_d = 1'b0;
          else        tx_d   = {tx_q[DATA_W-2:0], 1'b0};
        end
      end

      default: state_d = S_IDLE;
    endcase

    miso_d = (state_d == S_DATA) & tx_d[DATA_W-1];
  end

  // Flatten the bank onto the output bus
  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign regs[g*DATA_W +: DATA_W] = regs_q[g];
  end

  assign spi.miso    = miso_q;
  assign spi.miso_oe = ss_act;
  assign wr_strobe   = wr_strobe_q;
  assign wr_addr     = wr_addr_q;
  assign frame_err   = frame_err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Bench for spi_reg_slave: one default instance (8-bit, 8 regs, active-high
// select) and one wide instance (16-bit, 16 regs, active-low select, nonzero
// reset value) sharing sclk/mosi, with a bit-banged SPI master.
module tb_spi_reg_slave;

  localparam int HALF = 8;

  // Clock / reset
  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Master side stimulus
  logic sclk = 1'b0, mosi = 1'b0, cpol = 1'b0, cpha = 1'b0, sel_act = 1'b0;
  int   dut_sel = 0;
  int   dw      = 8;

  spi_reg_slave_if if0();
  spi_reg_slave_if if1();

  assign if0.ss   = (dut_sel == 0) && sel_act;
  assign if1.ss   = !((dut_sel == 1) && sel_act);
  assign if0.sclk = sclk;
  assign if1.sclk = sclk;
  assign if0.mosi = mosi;
  assign if1.mosi = mosi;

  logic [63:0]  regs0;
  logic         wr_strobe0, frame_err0;
  logic [2:0]   wr_addr0;
  logic [1:0]   dbg0;
  logic [255:0] regs1;
  logic         wr_strobe1, frame_err1;
  logic [3:0]   wr_addr1;
  logic [1:0]   dbg1;

  spi_reg_slave dut0 (
    .sys_clk(sys_clk), .rst_n(rst_n), .spi(if0), .cpol(cpol), .cpha(cpha),
    .regs(regs0), .wr_strobe(wr_strobe0), .wr_addr(wr_addr0),
    .frame_err(frame_err0), .dbg_state(dbg0)
  );

  spi_reg_slave #(
    .DATA_W(16), .ADDR_W(4), .SS_ACTIVE(1'b0), .RESET_VAL(16'hC3A5)
  ) dut1 (
    .sys_clk(sys_clk), .rst_n(rst_n), .spi(if1), .cpol(cpol), .cpha(cpha),
    .regs(regs1), .wr_strobe(wr_strobe1), .wr_addr(wr_addr1),
    .frame_err(frame_err1), .dbg_state(dbg1)
  );

  // Scoreboard state
  int n_checks = 0;
  int n_errors = 0;
  int ferr0 = 0, ferr1 = 0, exp_ferr0 = 0;
  logic [19:0] exp_q0[$];
  logic [19:0] exp_q1[$];
  logic [7:0]  model0[8];
  logic [15:0] model1[16];
  logic [15:0] tx_words[$];
  logic [15:0] rx_words[$];
  logic [15:0] r;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] flat0();
    logic [255:0] f = '0;
    for (int i = 0; i < 8; i++) f[i*8 +: 8] = model0[i];
    return f;
  endfunction

  function automatic logic [255:0] flat1();
    logic [255:0] f = '0;
    for (int i = 0; i < 16; i++) f[i*16 +: 16] = model1[i];
    return f;
  endfunction

  task automatic push_wr0(input int addr, input logic [7:0] data);
    exp_q0.push_back({1'b0, 3'(addr), 8'h00, data});
    model0[addr] = data;
  endtask

  task automatic push_wr1(input int addr, input logic [15:0] data);
    exp_q1.push_back({4'(addr), data});
    model1[addr] = data;
  endtask

  // Monitor: pop an expected write whenever a strobe appears
  always @(negedge sys_clk) begin
    logic [19:0] e;
    if (rst_n) begin
      if (wr_strobe0) begin
        if (exp_q0.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_wr0: got strobe addr %0d expected none", wr_addr0);
        end else begin
          e = exp_q0.pop_front();
          chk("wr_addr0", wr_addr0, e[18:16]);
          chk("wr_data0", regs0[wr_addr0*8 +: 8], e[7:0]);
        end
      end
      if (wr_strobe1) begin
        if (exp_q1.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_wr1: got strobe addr %0d expected none", wr_addr1);
        end else begin
          e = exp_q1.pop_front();
          chk("wr_addr1", wr_addr1, e[19:16]);
          chk("wr_data1", regs1[wr_addr1*16 +: 16], e[15:0]);
        end
      end
      if (frame_err0) ferr0++;
      if (frame_err1) ferr1++;
    end
  end

  // Driver tasks (inputs change on the falling sys_clk edge)
  task automatic wait_clk(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  function automatic logic miso_pin();
    return (dut_sel == 1) ? if1.miso : if0.miso;
  endfunction

  task automatic set_mode(input int m);
    cpol = m[1];
    cpha = m[0];
  endtask

  task automatic spi_bits(input logic [15:0] w, input int n, output logic [15:0] rd);
    rd = '0;
    for (int i = 0; i < n; i++) begin
      if (!cpha) begin
        mosi = w[dw-1-i];
        wait_clk(HALF);
        sclk = ~cpol;
        rd = {rd[14:0], miso_pin()};
        wait_clk(HALF);
        sclk = cpol;
      end else begin
        sclk = ~cpol;
        mosi = w[dw-1-i];
        wait_clk(HALF);
        sclk = cpol;
        rd = {rd[14:0], miso_pin()};
        wait_clk(HALF);
      end
    end
  endtask

  task automatic frame_begin();
    sclk = cpol;
    wait_clk(HALF);
    sel_act = 1'b1;
    wait_clk(HALF);
  endtask

  task automatic frame_end();
    wait_clk(HALF);
    sel_act = 1'b0;
    wait_clk(2*HALF);
  endtask

  task automatic run_frame();
    logic [15:0] rd;
    frame_begin();
    rx_words.delete();
    foreach (tx_words[i]) begin
      spi_bits(tx_words[i], dw, rd);
      rx_words.push_back(rd);
    end
    frame_end();
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_regs0"}, regs0, flat0());
    chk({tag, "_regs1"}, regs1, flat1());
    chk({tag, "_ferr0"}, ferr0, exp_ferr0);
    chk({tag, "_ferr1"}, ferr1, 0);
    chk({tag, "_q0_empty"}, exp_q0.size(), 0);
    chk({tag, "_q1_empty"}, exp_q1.size(), 0);
  endtask

  // Watchdog
  initial begin
    #600000;
    $display("FAIL watchdog: got no finish expected finish within 60000 cycles");
    $fatal(1, "watchdog");
  end

  // Directed test sequence
  initial begin
    for (int i = 0; i < 8; i++)  model0[i] = 8'h00;
    for (int i = 0; i < 16; i++) model1[i] = 16'hC3A5;
    wait_clk(3);

    // Reset values
    chk("rst_regs0", regs0, flat0());
    chk("rst_regs1", regs1, flat1());
    chk("rst_miso0", if0.miso, 1'b0);
    chk("rst_oe0", if0.miso_oe, 1'b0);
    chk("rst_oe1", if1.miso_oe, 1'b0);
    chk("rst_strobe0", wr_strobe0, 1'b0);
    chk("rst_ferr0", frame_err0, 1'b0);
    chk("rst_state0", dbg0, 2'd0);
    rst_n = 1'b1;
    wait_clk(4);

    // Single write, mode 0
    set_mode(0);
    tx_words = '{16'h83, 16'hA5};
    push_wr0(3, 8'hA5);
    run_frame();
    check_state("wr1");

    // Burst write wrapping 7 -> 0
    tx_words = '{16'h87, 16'h11, 16'h22};
    push_wr0(7, 8'h11);
    push_wr0(0, 8'h22);
    run_frame();
    check_state("burst");

    // Preload reg5 and read it back in all four modes
    tx_words = '{16'h85, 16'h3C};
    push_wr0(5, 8'h3C);
    run_frame();
    check_state("preload");
    for (int m = 0; m < 4; m++) begin
      set_mode(m);
      tx_words = '{16'h05, 16'h00};
      run_frame();
      chk($sformatf("rd_cmd_miso_m%0d", m), rx_words[0], 16'h0000);
      chk($sformatf("rd_data_m%0d", m), rx_words[1], 16'h003C);
      check_state($sformatf("rd_m%0d", m));
    end

    // Burst read across the wrap, mode 3
    tx_words = '{16'h07, 16'h00, 16'h00};
    run_frame();
    chk("rdwrap_w1", rx_words[1], 16'h0011);
    chk("rdwrap_w2", rx_words[2], 16'h0022);
    check_state("rdwrap");

    // Abort mid-word: frame_err once, reg2 untouched, next frame works
    set_mode(0);
    frame_begin();
    spi_bits(16'h82, 8, r);
    spi_bits(16'hF0, 4, r);
    frame_end();
    exp_ferr0 = 1;
    check_state("abort");
    tx_words = '{16'h82, 16'h5A};
    push_wr0(2, 8'h5A);
    run_frame();
    check_state("after_abort");

    // Async reset in the middle of a read of reg1 = 0xFF
    tx_words = '{16'h81, 16'hFF};
    push_wr0(1, 8'hFF);
    run_frame();
    check_state("pre_rst");
    frame_begin();
    spi_bits(16'h01, 8, r);
    spi_bits(16'h00, 3, r);
    wait_clk(2);
    chk("mid_state0", dbg0, 2'd2);
    chk("mid_miso0", if0.miso, 1'b1);
    chk("mid_oe0", if0.miso_oe, 1'b1);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) model0[i] = 8'h00;
    chk("arst_regs0", regs0, flat0());
    chk("arst_regs1", regs1, flat1());
    chk("arst_miso0", if0.miso, 1'b0);
    chk("arst_oe0", if0.miso_oe, 1'b0);
    chk("arst_state0", dbg0, 2'd0);
    chk("arst_strobe0", wr_strobe0, 1'b0);
    chk("arst_ferr0", frame_err0, 1'b0);
    sel_act = 1'b0;
    sclk = cpol;
    wait_clk(2*HALF);
    rst_n = 1'b1;
    wait_clk(4);
    tx_words = '{16'h83, 16'hA5};
    push_wr0(3, 8'hA5);
    run_frame();
    check_state("post_rst");

    // Wide instance: 16-bit words, 16 regs, active-low select
    dut_sel = 1;
    dw = 16;
    set_mode(0);
    tx_words = '{16'h800A, 16'hBEEF};
    push_wr1(10, 16'hBEEF);
    run_frame();
    check_state("wide_wr");
    chk("wide_state", dbg1, 2'd0);
    set_mode(2);
    tx_words = '{16'h000A, 16'h0000};
    run_frame();
    chk("wide_rd", rx_words[1], 16'hBEEF);
    check_state("wide_rd");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_reg_slave.md
# spi_reg_slave

Parametrised SPI slave with an on-chip register bank, the next-generation replacement for the fixed 8-bit, mode-0-only SPI front end of the top-level design. SPI pins are oversampled in the `sys_clk` domain. The block supports all four CPOL/CPHA modes at run time, a configurable word width, and read as well as write. Bursts auto-increment the address within one `ss` window. Register contents drive the design's GPIO/mode outputs through a flat bus.

## Interface
Parameters:
- DATA_W, 8, SPI word and register width (≥ ADDR_W+1, ≥ 4)
- ADDR_W, 3, register address width; NREGS = 2**ADDR_W
- SS_ACTIVE, 1, asserted level of `ss` (1 matches the current top level)
- RESET_VAL, 0, reset value of every register (DATA_W bits)

Ports:
- sys_clk  in  1  system clock; all logic on its rising edge
- rst_n  in  1  asynchronous active-low reset
- ss  in  1  slave select, async, level SS_ACTIVE = selected
- sclk  in  1  SPI clock, async
- mosi  in  1  master-out data, async
- cpol  in  1  clock idle level; sampled only while `ss` (synced) is inactive
- cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge; same sampling rule as cpol
- miso  out  1  slave-out data, MSB first
- miso_oe  out  1  high while selected (for pad tristate)
- regs  out  NREGS*DATA_W  flat register bank; reg i at [i*DATA_W +: DATA_W]
- wr_strobe  out  1  one-cycle pulse when a register is written
- wr_addr  out  ADDR_W  address of that write, valid with wr_strobe
- frame_err  out  1  one-cycle pulse when `ss` deasserts mid-word

## Operation
- Input sync: `ss`, `sclk` and `mosi` each pass through 2 flops. Edges are detected on synced `sclk` by comparing with the previous sample.
- Leading edge = idle→active transition (rising if cpol=0). Sample edge = leading if cpha=0, else trailing. Shift edge = the other one.
- FSM states: IDLE, CMD, DATA.
  - IDLE→CMD on synced ss assert. Bit counter is cleared; cpol/cpha are latched.
  - CMD: receive DATA_W bits MSB first. Bit[DATA_W-1] = 1 means write, 0 means read. Bits[ADDR_W-1:0] = start address; the remaining bits are ignored.
  - After the last CMD sample, go to DATA. For a read, reg[addr] is loaded into the tx shift register.
  - DATA: each complete word is handled as follows:
    - Write: regs[addr] ← word; wr_strobe is pulsed with wr_addr = addr.
    - Read: the word received on mosi is discarded.
    - Then addr ← addr+1 mod NREGS (wrap from NREGS-1 to 0). For a read, reg[new addr] is loaded for the next word.
  - Any state→IDLE on synced ss deassert.
- Partial word at deassert: discarded, no register write; frame_err pulses if bit count ≠ 0.
- miso:
  - Outputs 0 during CMD and in IDLE.
  - In DATA read, it is the tx MSB. The tx register shifts left on each shift edge.
  - cpha=0: the new MSB is on miso before the first leading edge of the word.
  - cpha=1: the MSB is presented at the first leading edge of the word.
- miso_oe = synced ss active.
- Write and read of the same register in the same cycle cannot occur (single master).

## Timing
- Reset (rst_n low, async): FSM IDLE, all regs = RESET_VAL, miso 0, miso_oe 0, wr_strobe 0, frame_err 0, counters 0.
- Deassert of rst_n is taken synchronously: first active edge after release.
- SPI requirements: sclk high and low phases ≥ 3 sys_clk periods each. ss setup to first sclk edge ≥ 3 sys_clk. ss hold after last edge ≥ 3 sys_clk. mosi stable around the sample edge ≥ 3 sys_clk.
- Latencies:
  - Pin to internal: 2 cycles. Edge detect: +1 cycle.
  - Register update and wr_strobe: 1 cycle after the final sample edge is detected, i.e. 4 sys_clk after the pin edge.
  - Read load: same cycle as the write-equivalent point.
  - miso changes 1 cycle after the shift edge is detected (4 sys_clk after the pin edge).
- ss deassert mid-word: aborts within 3 cycles. ss reassert starts a fresh CMD.
- cpol/cpha changing while selected: ignored until the next IDLE.
- rst_n mid-frame: immediate abort, no partial write, regs return to RESET_VAL.

## Test plan
- Write: reset, mode 0, frame {0x83, 0xA5} → regs[3]=0xA5, one wr_strobe with wr_addr=3, others = RESET_VAL.
- Burst write with wrap: mode 0, {0x87, 0x11, 0x22} with ADDR_W=3 → reg7=0x11, reg0=0x22, two strobes (addr 7, then 0).
- Read in all 4 modes: preload reg5=0x3C, frame {0x05, 0x00} → master captures 0x3C on miso's second word in each of modes 0–3; no wr_strobe.
- Abort: send 0x82 then 4 bits of data, deassert ss → frame_err pulses once, reg2 unchanged; the next full frame works.
- Async reset mid-frame: pull rst_n low during DATA → all outputs at reset values immediately, regs = RESET_VAL.
- Parameter sweep: DATA_W=16, ADDR_W=4, SS_ACTIVE=0, frame {0x800A, 0xBEEF} → regs[10]=0xBEEF.
